v_word_splitter: RTL and testbench

//   Downstream width converter for the 64-bit d-port word (2*`ThirtyTwo) produced by the port-decl test block.

---
 rtl/v_word_splitter.sv | 99 +++++++++
 tb/tb_v_word_splitter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/v_word_splitter.sv
// Splits each 2*OUT_W-bit input word into OUT_W-bit output beats, low half first.
// Define V_WORD_SPLIT_STATS_EN to add the wrapping 16-bit word_cnt completion counter.
//
// state | meaning
// IDLE  | holding register empty, waiting for a word
// LO    | low half presented on out_data
// HI    | high half presented on out_data (always the last beat)
module v_word_splitter #(
    parameter int OUT_W = 32
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*OUT_W-1:0] in_data,
    input  logic               in_half,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_last
`ifdef V_WORD_SPLIT_STATS_EN
    ,
    output logic [15:0]        word_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } state_t;

    state_t             stateReg;
    state_t             stateNext;
    logic [2*OUT_W-1:0] holdData;
    logic               holdHalf;
    logic               readyEn;
    logic               accept;
    logic               wordDone;

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            stateReg <= IDLE;
            holdData <= '0;
            holdHalf <= 1'b0;
            readyEn  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            readyEn  <= 1'b1;
            if (accept) begin
                holdData <= in_data;
                holdHalf <= in_half;
            end
        end
    end

    always_comb begin
        out_valid = (stateReg != IDLE);
        out_data  = '0;
        out_last  = 1'b0;
        case (stateReg)
            LO: begin
                out_data = holdData[OUT_W-1:0];
                out_last = holdHalf;
            end
            HI: begin
                out_data = holdData[2*OUT_W-1:OUT_W];
                out_last = 1'b1;
            end
            default: ;
        endcase

        wordDone = out_valid & out_ready & out_last;
        // A finishing word frees the holding register in the same cycle, so the next word
        // can be taken without an idle bubble.
        in_ready = readyEn & ((stateReg == IDLE) | wordDone);
        accept   = in_valid & in_ready;

        stateNext = stateReg;
        if (accept) begin
            stateNext = LO;
        end else if (wordDone) begin
            stateNext = IDLE;
        end else if ((stateReg == LO) && out_ready) begin
            stateNext = HI;
        end
    end

`ifdef V_WORD_SPLIT_STATS_EN
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            word_cnt <= 16'h0000;
        end else if (wordDone) begin
            word_cnt <= word_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_v_word_splitter.sv
// Self-checking bench for v_word_splitter: directed cases plus random traffic against a
// beat-queue reference model. Honours V_WORD_SPLIT_STATS_EN for the word_cnt checks.
module tb_v_word_splitter;

    localparam int OUT_W = 32;

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             last;
    } beat_t;

    logic               clk = 1'b0;
    logic               reset_l = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [2*OUT_W-1:0] in_data = '0;
    logic               in_half = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic               out_last;
`ifdef V_WORD_SPLIT_STATS_EN
    logic [15:0]        word_cnt;
`endif

    v_word_splitter #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_half   (in_half),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
`ifdef V_WORD_SPLIT_STATS_EN
        ,
        .word_cnt  (word_cnt)
`endif
    );

    always #5 clk = ~clk;

    int    nCmp = 0;
    int    nErr = 0;

    // reference model: pending output beats of the word in flight
    beat_t              beatQ[$];
    bit                 isUp = 0;
    bit                 hsPend = 0;
    bit                 accPend = 0;
    logic [2*OUT_W-1:0] accData = '0;
    bit                 accHalf = 0;
    int                 wordsDone = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit v, input bit h, input logic [2*OUT_W-1:0] d, input bit r);
        bit expV;
        bit expRdy;
        @(posedge clk);
        if (reset_l) begin
            if (hsPend) begin
                if (beatQ[0].last) wordsDone++;
                void'(beatQ.pop_front());
            end
            if (accPend) begin
                beatQ.push_back('{d: accData[OUT_W-1:0], last: accHalf});
                if (!accHalf) beatQ.push_back('{d: accData[2*OUT_W-1:OUT_W], last: 1'b1});
            end
            isUp = 1;
        end
        hsPend  = 0;
        accPend = 0;
        #1;
        in_valid  = v;
        in_half   = h;
        in_data   = v ? d : {2*OUT_W{1'bx}};
        out_ready = r;
        #3;
        expV   = (beatQ.size() > 0);
        expRdy = isUp && (!expV || (r && beatQ[0].last));
        check("in_ready", {63'd0, in_ready}, {63'd0, expRdy});
        check("out_valid", {63'd0, out_valid}, {63'd0, expV});
        if (expV) begin
            check("out_data", {32'd0, out_data}, {32'd0, beatQ[0].d});
            check("out_last", {63'd0, out_last}, {63'd0, beatQ[0].last});
        end
`ifdef V_WORD_SPLIT_STATS_EN
        check("word_cnt", {48'd0, word_cnt}, {48'd0, wordsDone[15:0]});
`endif
        hsPend  = expV && r;
        accPend = v && expRdy;
        accData = d;
        accHalf = h;
    endtask

    task automatic modelReset();
        beatQ.delete();
        isUp      = 0;
        hsPend    = 0;
        accPend   = 0;
        wordsDone = 0;
    endtask

    task automatic checkInReset(input string tag);
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_out_data"}, {32'd0, out_data}, 64'd0);
        check({tag, "_out_last"}, {63'd0, out_last}, 64'd0);
`ifdef V_WORD_SPLIT_STATS_EN
        check({tag, "_word_cnt"}, {48'd0, word_cnt}, 64'd0);
`endif
    endtask

    initial begin
        // reset held with a valid word offered: nothing may be accepted
        reset_l  = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'hFFFF_0000_AAAA_5555;
        modelReset();
        repeat (3) begin
            @(negedge clk);
            checkInReset("rst");
        end
        #2 reset_l = 1'b1;
        #1 check("rel_in_ready_before_edge", {63'd0, in_ready}, 64'd0);

        // full word, then half word, then backpressure during LO
        step(1, 0, 64'h0123_4567_89AB_CDEF, 1);
        step(0, 0, 64'd0, 1);
        step(0, 0, 64'd0, 1);
        step(1, 1, 64'hDEAD_BEEF_0000_1111, 1);
        step(0, 0, 64'd0, 1);
        step(1, 0, 64'hCAFE_F00D_1234_5678, 1);
        repeat (5) step(0, 0, 64'd0, 0);
        repeat (3) step(0, 0, 64'd0, 1);

        // four back-to-back full words, then drain
        for (int i = 0; i < 4; i++) begin
            step(1, 0, {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)}, 1);
            step(1, 0, {32'h1000_0000 + 32'(i + 1), 32'h2000_0000 + 32'(i + 1)}, 1);
        end
        repeat (3) step(0, 0, 64'd0, 1);

        // back-to-back half words
        for (int i = 0; i < 4; i++) step(1, 1, {32'hBAD0_0000, 32'h3000_0000 + 32'(i)}, 1);
        repeat (2) step(0, 0, 64'd0, 1);

        // reset while the high beat is presented
        step(1, 0, 64'h7777_6666_5555_4444, 1);
        step(0, 0, 64'd0, 1);
        step(0, 0, 64'd0, 0);
        #2 reset_l = 1'b0;
        #1 checkInReset("midrst");
        modelReset();
        repeat (2) @(negedge clk);
        checkInReset("midrst_hold");
        #2 reset_l = 1'b1;
        step(1, 0, 64'h9999_8888_ABCD_0001, 1);
        repeat (3) step(0, 0, 64'd0, 1);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
                 {$urandom(), $urandom()}, ($urandom_range(0, 9) < 7));
        end
        repeat (4) step(0, 0, 64'd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
